// File: rtl/ldtu_pkg.sv
// Shared LiTe-DTU constants: encoder state classes, their code ranges,
// output word headers and the idle filler word.
package ldtu_pkg;

  typedef enum logic [2:0] {
    CL_IDLE = 3'd0,
    CL_BAS  = 3'd1,
    CL_SIG  = 3'd2,
    CL_BC0  = 3'd3,
    CL_HDR  = 3'd4
  } st_class_e;

  localparam int BW = 6;
  localparam int SW = 13;
  localparam int NB = 5;

  // Encoder state codes grouped by class
  localparam logic [4:0] BAS_LO_A = 5'd1;
  localparam logic [4:0] BAS_HI_A = 5'd5;
  localparam logic [4:0] BAS_LO_B = 5'd8;
  localparam logic [4:0] BAS_HI_B = 5'd12;
  localparam logic [4:0] SIG_A    = 5'd6;
  localparam logic [4:0] SIG_B    = 5'd7;
  localparam logic [4:0] SIG_C    = 5'd13;
  localparam logic [4:0] SIG_D    = 5'd14;
  localparam logic [4:0] BC0_LO   = 5'd15;
  localparam logic [4:0] BC0_HI   = 5'd19;
  localparam logic [4:0] BC0_A    = 5'd22;
  localparam logic [4:0] BC0_B    = 5'd24;
  localparam logic [4:0] HDR_A    = 5'd20;
  localparam logic [4:0] HDR_B    = 5'd21;
  localparam logic [4:0] HDR_C    = 5'd23;

  localparam logic [1:0]  HDR_BASE  = 2'b01;
  localparam logic [3:0]  HDR_PART  = 4'b1110;
  localparam logic [5:0]  HDR_SIG2  = 6'b001010;
  localparam logic [5:0]  HDR_SIG1  = 6'b001011;
  localparam logic [3:0]  HDR_HDR   = 4'b0101;
  localparam logic [31:0] IDLE_WORD = 32'hEAAAAAAA;

endpackage

// File: rtl/ldtu_data_packer_if.sv
// Sample/state input bus and packed-word output bus of the data packer.
interface ldtu_data_packer_if;
  logic [4:0]  Current_state;
  logic        fallback;
  logic [12:0] sample_in;
  logic [31:0] data_out;
  logic        data_valid;
  logic        drop_err;

  modport master (
    output Current_state, fallback, sample_in,
    input  data_out, data_valid, drop_err
  );

  modport slave (
    input  Current_state, fallback, sample_in,
    output data_out, data_valid, drop_err
  );
endinterface

// File: rtl/ldtu_state_class.sv
// Combinational decoder from the 5-bit encoder state to its packing class.
module ldtu_state_class
  import ldtu_pkg::*;
(
  input  logic [4:0] state,
  output st_class_e  cls
);

  always_comb begin
    cls = CL_IDLE;
    if ((state >= BAS_LO_A && state <= BAS_HI_A) ||
        (state >= BAS_LO_B && state <= BAS_HI_B))
      cls = CL_BAS;
    else if (state == SIG_A || state == SIG_B || state == SIG_C || state == SIG_D)
      cls = CL_SIG;
    else if ((state >= BC0_LO && state <= BC0_HI) || state == BC0_A || state == BC0_B)
      cls = CL_BC0;
    else if (state == HDR_A || state == HDR_B || state == HDR_C)
      cls = CL_HDR;
  end

endmodule

// File: rtl/ldtu_data_packer.sv
// LiTe-DTU packer: baseline/signal samples into 32-bit words, one cycle latency.
// Define LDTU_PACKER_IDLE_WORD_EN to drive the idle word on non-valid cycles.
module ldtu_data_packer
  import ldtu_pkg::*;
(
  input  logic                 CLK,
  input  logic                 rst_b,
  ldtu_data_packer_if.slave    bus
);

  st_class_e cls;

  logic [NB-1:0][BW-1:0] bbuf_q, bbuf_d;
  logic [1:0][SW-1:0]    sbuf_q, sbuf_d;
  logic [2:0]            bcnt_q, bcnt_d;
  logic [1:0]            scnt_q, scnt_d;
  logic [15:0]           hdr_cnt_q, hdr_cnt_d;
  logic [31:0]           data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  drop_err_q, drop_err_d;

  logic                  emit, clr;
  logic [31:0]           word;
  logic [3:0][BW-1:0]    part;
  logic [31:0]           w_single, w_part;

  ldtu_state_class u_class (
    .state (bus.Current_state),
    .cls   (cls)
  );

  always_comb begin
    for (int i = 0; i < 4; i++)
      part[i] = (i < int'(bcnt_q)) ? bbuf_q[i] : '0;
    w_single = {HDR_SIG1, 13'h0, sbuf_q[0]};
    w_part   = {HDR_PART, {1'b0, bcnt_q}, part};
  end

  always_comb begin
    bbuf_d     = bbuf_q;
    sbuf_d     = sbuf_q;
    bcnt_d     = bcnt_q;
    scnt_d     = scnt_q;
    hdr_cnt_d  = hdr_cnt_q;
    drop_err_d = drop_err_q;
    emit       = 1'b0;
    clr        = 1'b0;
    word       = '0;

    if (bus.fallback) begin
      clr = 1'b1;
    end else begin
      case (cls)
        // Only one buffer can be occupied, so a flush and a completion never collide.
        CL_BAS: begin
          if (scnt_q == 2'd1) begin
            emit   = 1'b1;
            word   = w_single;
            scnt_d = '0;
            sbuf_d = '0;
          end
          if (bcnt_q == 3'(NB - 1)) begin
            emit   = 1'b1;
            word   = {HDR_BASE, bus.sample_in[BW-1:0], bbuf_q[3], bbuf_q[2], bbuf_q[1], bbuf_q[0]};
            bcnt_d = '0;
            bbuf_d = '0;
          end else begin
            bbuf_d[bcnt_q] = bus.sample_in[BW-1:0];
            bcnt_d         = bcnt_q + 3'd1;
          end
        end
        CL_SIG: begin
          if (bcnt_q != '0) begin
            emit   = 1'b1;
            word   = w_part;
            bcnt_d = '0;
            bbuf_d = '0;
          end
          if (scnt_q == 2'd1) begin
            emit   = 1'b1;
            word   = {HDR_SIG2, bus.sample_in, sbuf_q[0]};
            scnt_d = '0;
            sbuf_d = '0;
          end else begin
            sbuf_d[scnt_q[0]] = bus.sample_in;
            scnt_d            = scnt_q + 2'd1;
          end
        end
        CL_BC0: begin
          clr = 1'b1;
          if (scnt_q == 2'd1) begin
            emit = 1'b1;
            word = w_single;
          end else if (bcnt_q != '0) begin
            emit = 1'b1;
            word = w_part;
          end
        end
        CL_HDR: begin
          clr       = 1'b1;
          emit      = 1'b1;
          word      = {HDR_HDR, 12'h000, hdr_cnt_q};
          hdr_cnt_d = hdr_cnt_q + 16'd1;
          if (bcnt_q != '0 || scnt_q != '0) drop_err_d = 1'b1;
        end
        default: clr = 1'b1;
      endcase
    end

    if (clr) begin
      bcnt_d = '0;
      scnt_d = '0;
      bbuf_d = '0;
      sbuf_d = '0;
    end

    data_valid_d = emit;
`ifdef LDTU_PACKER_IDLE_WORD_EN
    data_out_d = emit ? word : IDLE_WORD;
`else
    data_out_d = emit ? word : data_out_q;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!rst_b) begin
      bbuf_q       <= '0;
      sbuf_q       <= '0;
      bcnt_q       <= '0;
      scnt_q       <= '0;
      hdr_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      bbuf_q       <= bbuf_d;
      sbuf_q       <= sbuf_d;
      bcnt_q       <= bcnt_d;
      scnt_q       <= scnt_d;
      hdr_cnt_q    <= hdr_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.drop_err   = drop_err_q;

endmodule

// File: doc/ldtu_data_packer.md
LDTU_DATA_PACKER -- requirements
Module: ldtu_data_packer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low (CLK, rst_b).
REQ-002 CLK  in  1  LiTe-DTU clock; all state updates on posedge.
REQ-003 rst_b  in  1  synchronous active-low reset.
REQ-004 Current_state  in  5  encoder FSM state for the sample presented in the same cycle.
REQ-005 fallback  in  1  1 = fallback mode: packer cleared, no output words.
REQ-006 sample_in  in  13  sample, time-aligned with Current_state; baseline payload = sample_in[5:0].
REQ-007 data_out  out  32  packed output word, registered.
REQ-008 data_valid  out  1  1-cycle strobe qualifying data_out.
REQ-009 drop_err  out  1  sticky: pending data discarded by a header.

Function
REQ-010 Current_state SHALL be classified as follows: BAS = 1..5, 8..12; SIG = 6, 7, 13, 14; BC0 = 15..19, 22, 24; HDR = 20, 21, 23; IDLE = 0 and 25..31.
REQ-011 The block SHALL keep a baseline buffer (5 x 6 bit, count bcnt 0..5) and a signal buffer (2 x 13 bit, count scnt 0..2); at most one of bcnt, scnt SHALL be nonzero.
REQ-012 BAS cycle: if scnt==1, the block SHALL emit the single-signal word {6'b001011, 13'h0, s0} and clear scnt, and SHALL then store the sample at slot bcnt and increment bcnt.
REQ-013 On the BAS cycle that makes bcnt=5, the block SHALL emit the baseline word {2'b01, b4, b3, b2, b1, b0} and clear bcnt; b0 is the oldest sample.
REQ-014 SIG cycle: if bcnt>0, the block SHALL emit the partial-baseline word {4'b1110, 4'(bcnt), slots3..0}, zero-filling unused slots, and clear bcnt; it SHALL then store the sample as s[scnt].
REQ-015 On the SIG cycle that makes scnt=2, the block SHALL emit the signal word {6'b001010, s1, s0} and clear scnt.
REQ-016 BC0 cycle: the block SHALL flush any pending partial-baseline or single-signal word per REQ-012/014, discard the sample, and emit nothing if both buffers are empty.
REQ-017 HDR cycle: the block SHALL emit the header word {4'b0101, 12'h000, hdr_cnt[15:0]} and then increment hdr_cnt, wrapping 16'hFFFF to 0; the first header after reset carries 0.
REQ-018 HDR cycle with a nonzero buffer: the header SHALL win, the buffers SHALL be cleared without emission, and drop_err SHALL be set.
REQ-019 IDLE cycle, or fallback=1: buffers SHALL be cleared without emission, with hdr_cnt kept.
REQ-020 Latency: a word SHALL appear on data_out with data_valid=1 exactly one cycle after the completing cycle; no more than one word per cycle.
REQ-021 When data_valid=0, data_out SHALL hold its last value unless LDTU_PACKER_IDLE_WORD_EN is defined.

Reset
REQ-022 rst_b=0 SHALL force data_out=0, data_valid=0, drop_err=0, bcnt=scnt=0, hdr_cnt=0 and all buffer slots to 0.
REQ-023 Reset mid-word SHALL discard pending samples with no flush word.
REQ-024 Only reset SHALL clear drop_err.

Configuration
REQ-025 With LDTU_PACKER_IDLE_WORD_EN defined, non-valid cycles SHALL drive data_out=32'hEAAAAAAA.
REQ-026 Without LDTU_PACKER_IDLE_WORD_EN, non-valid cycles SHALL hold data_out (REQ-021); the reset value is 0 in both cases.

Structure
REQ-027 A shared package ldtu_pkg SHALL hold the 5-bit state codes, the class ranges, the word headers (2'b01, 4'b1110, 6'b001010, 6'b001011, 4'b0101) and the idle word constant.
REQ-028 The block SHALL contain one sub-module, ldtu_state_class, a combinational decoder from Current_state to {BAS, SIG, BC0, HDR, IDLE}; all sequential logic SHALL live in ldtu_data_packer.

Verification
REQ-029 Five BAS cycles with samples 1,2,3,4,5 -> one cycle later data_out={2'b01,6'd5,6'd4,6'd3,6'd2,6'd1}, data_valid=1 for exactly 1 cycle.
REQ-030 BAS(7), BAS(9), then SIG(13'h1ABC) -> data_out=32'hE2000247 with data_valid pulsed, then scnt=1.
REQ-031 SIG(13'h0001), SIG(13'h1FFF) -> data_out={6'b001010,13'h1FFF,13'h0001}, data_valid pulsed.
REQ-032 BC0 then HDR twice from reset -> header words with hdr_cnt 0 then 1; preload hdr_cnt=16'hFFFF -> next header carries 0.
REQ-033 BAS(3) then HDR -> header emitted, no partial word, drop_err=1 until rst_b=0.
REQ-034 rst_b=0 for one cycle after 3 BAS cycles, then 5 BAS cycles -> only one full baseline word containing the post-reset samples; idle word 32'hEAAAAAAA is checked with LDTU_PACKER_IDLE_WORD_EN defined.
